// File: rtl/ec_point_encoder_if.sv
// rtl/ec_point_encoder_if.sv - request, byte-stream and error bundle of the SEC1 point encoder
interface ec_point_encoder_if #(
    parameter int MAX_BYTES = 66,
    parameter int OUT_BYTES = 4,
    parameter int NB_W      = $clog2(MAX_BYTES + 1)
);
    logic                     in_valid;
    logic                     in_ready;
    logic [8*MAX_BYTES-1:0]   in_x;
    logic [8*MAX_BYTES-1:0]   in_y;
    logic                     in_inf;
    logic [1:0]               in_mode;
    logic [NB_W-1:0]          in_nbytes;
    logic                     out_valid;
    logic                     out_ready;
    logic [8*OUT_BYTES-1:0]   out_data;
    logic [OUT_BYTES-1:0]     out_keep;
    logic                     out_last;
    logic                     err_valid;
    logic [1:0]               err_code;
    logic                     busy;

    modport master (
        output in_valid, in_x, in_y, in_inf, in_mode, in_nbytes, out_ready,
        input  in_ready, out_valid, out_data, out_keep, out_last, err_valid, err_code, busy
    );

    modport slave (
        input  in_valid, in_x, in_y, in_inf, in_mode, in_nbytes, out_ready,
        output in_ready, out_valid, out_data, out_keep, out_last, err_valid, err_code, busy
    );
endinterface

// File: rtl/ec_point_encoder.sv
// rtl/ec_point_encoder.sv - SEC1 EC point serializer (uncompressed / compressed / raw X)
module ec_point_encoder #(
    parameter int MAX_BYTES = 66,
    parameter int OUT_BYTES = 4,
    parameter int NB_W      = $clog2(MAX_BYTES + 1)
) (
    input  logic              clk,
    input  logic              rst,
    ec_point_encoder_if.slave bus
);
    localparam int CW = $clog2(2*MAX_BYTES + OUT_BYTES + 2);

    typedef enum logic [1:0] {IDLE, CHECK, EMIT} state_t;

    state_t                 state, state_nx;
    logic [8*MAX_BYTES-1:0] x_r, y_r;
    logic                   inf_r;
    logic [1:0]             mode_r;
    logic [NB_W-1:0]        n_r;
    logic [CW-1:0]          pos_r;
    logic                   out_valid_r, out_last_r, err_valid_r;
    logic [8*OUT_BYTES-1:0] out_data_r;
    logic [OUT_BYTES-1:0]   out_keep_r;
    logic [1:0]             err_code_r;

    logic                   in_ready, busy;
    logic [1:0]             chk_code;
    logic                   x_hi, y_hi;
    logic [CW-1:0]          nn, len;
    logic [8*OUT_BYTES-1:0] beat_data;
    logic [OUT_BYTES-1:0]   beat_keep;
    logic                   beat_last;

    // Byte k (0 = most significant) of an n-byte big-endian field.
    function automatic logic [7:0] coord_byte(input logic [8*MAX_BYTES-1:0] c,
                                              input logic [CW-1:0] n,
                                              input logic [CW-1:0] k);
        logic [CW-1:0]          idx;
        logic [8*MAX_BYTES-1:0] sh;
        idx = n - k - CW'(1);
        sh  = c >> {idx, 3'b000};
        return sh[7:0];
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (bus.in_valid) state_nx = CHECK;
            CHECK:   state_nx = (chk_code != 2'd0) ? IDLE : EMIT;
            EMIT:    if (out_valid_r && bus.out_ready && out_last_r) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        in_ready = (state == IDLE);
        busy     = (state != IDLE);
    end

    always_comb begin
        x_hi = 1'b0;
        y_hi = 1'b0;
        for (int b = 0; b < MAX_BYTES; b++) begin
            if (b >= int'(n_r)) begin
                if (x_r[8*b +: 8] != 8'h00) x_hi = 1'b1;
                if (y_r[8*b +: 8] != 8'h00) y_hi = 1'b1;
            end
        end
        chk_code = 2'd0;
        if (n_r == '0 || int'(n_r) > MAX_BYTES) begin
            chk_code = 2'd1;
        end else if (!inf_r) begin
            if (mode_r == 2'd3)                           chk_code = 2'd3;
            else if (x_hi || (mode_r == 2'd0 && y_hi))    chk_code = 2'd2;
        end
    end

    always_comb begin
        nn = CW'(n_r);
        if (inf_r) begin
            len = CW'(1);
        end else begin
            case (mode_r)
                2'd0:    len = nn + nn + CW'(1);
                2'd1:    len = nn + CW'(1);
                default: len = nn;
            endcase
        end
    end

    // Lanes past the packet end stay zero with keep cleared.
    always_comb begin
        logic [CW-1:0] j;
        logic [7:0]    b;
        beat_data = '0;
        beat_keep = '0;
        for (int i = 0; i < OUT_BYTES; i++) begin
            j = pos_r + CW'(i);
            b = 8'h00;
            if (j < len) begin
                if (!inf_r) begin
                    case (mode_r)
                        2'd0: begin
                            if (j == '0)     b = 8'h04;
                            else if (j <= nn) b = coord_byte(x_r, nn, j - CW'(1));
                            else             b = coord_byte(y_r, nn, j - CW'(1) - nn);
                        end
                        2'd1: begin
                            if (j == '0) b = {7'b0000001, y_r[0]};
                            else        b = coord_byte(x_r, nn, j - CW'(1));
                        end
                        default: b = coord_byte(x_r, nn, j);
                    endcase
                end
                beat_data[8*i +: 8] = b;
                beat_keep[i]        = 1'b1;
            end
        end
        beat_last = (pos_r + CW'(OUT_BYTES)) >= len;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_r         <= '0;
            y_r         <= '0;
            inf_r       <= 1'b0;
            mode_r      <= 2'd0;
            n_r         <= '0;
            pos_r       <= '0;
            out_valid_r <= 1'b0;
            out_data_r  <= '0;
            out_keep_r  <= '0;
            out_last_r  <= 1'b0;
            err_valid_r <= 1'b0;
            err_code_r  <= 2'd0;
        end else begin
            err_valid_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        x_r    <= bus.in_x;
                        y_r    <= bus.in_y;
                        inf_r  <= bus.in_inf;
                        mode_r <= bus.in_mode;
                        n_r    <= bus.in_nbytes;
                        pos_r  <= '0;
                    end
                end
                CHECK: begin
                    if (chk_code != 2'd0) begin
                        err_valid_r <= 1'b1;
                        err_code_r  <= chk_code;
                    end
                end
                EMIT: begin
                    if (!out_valid_r || bus.out_ready) begin
                        if (out_valid_r && out_last_r) begin
                            out_valid_r <= 1'b0;
                            out_data_r  <= '0;
                            out_keep_r  <= '0;
                            out_last_r  <= 1'b0;
                        end else begin
                            out_valid_r <= 1'b1;
                            out_data_r  <= beat_data;
                            out_keep_r  <= beat_keep;
                            out_last_r  <= beat_last;
                            pos_r       <= pos_r + CW'(OUT_BYTES);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.busy      = busy;
    assign bus.out_valid = out_valid_r;
    assign bus.out_data  = out_data_r;
    assign bus.out_keep  = out_keep_r;
    assign bus.out_last  = out_last_r;
    assign bus.err_valid = err_valid_r;
    assign bus.err_code  = err_code_r;
endmodule
